design_08_sequencer: RTL and testbench
======================================

Name: design_08_sequencer

Overview:
- Sequences one shared mkDesign_08 instance between two requesters (port 0, port 1) using round-robin arbitration.
- Each transaction runs start(a,b), then a result read with argument c, then check(d).
- The captured result and check values are returned to the requester that owns the transaction.
- A per-phase watchdog aborts transactions stalled on target RDY_* and returns an error response.

Parameters:
AW, 5, width of the a/b/c/d method arguments
RW, 5, width of the variable_1_result and variable_1_check return values
TMO, 255, maximum cycles to wait in one phase for a target RDY before abort; must be ≥1

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 command valid
req0_a / req0_b / req0_c / req0_d  in  AW each  requester 0 command arguments
req0_ready  out  1  requester 0 command accepted this cycle
req1_valid, req1_a, req1_b, req1_c, req1_d, req1_ready  same as port 0, for requester 1
rsp_valid  out  1  response valid
rsp_id  out  1  index of the requester that owns the response
rsp_result  out  RW  captured variable_1_result
rsp_check  out  RW  captured variable_1_check
rsp_err  out  1  transaction aborted by timeout
rsp_ready  in  1  response consumed
start_a / start_b  out  AW  start method arguments
EN_start  out  1  start method enable
RDY_start  in  1  start method ready
variable_1_result_c  out  AW  result method argument
variable_1_result  in  RW  result method value
RDY_variable_1_result  in  1  result method ready
variable_1_check_d  out  AW  check method argument
EN_variable_1_check  out  1  check method enable
variable_1_check  in  RW  check method value
RDY_variable_1_check  in  1  check method ready

Behaviour:
- Reset (RST=1 at an edge): state IDLE, rr_ptr=0, tmo_cnt=0, latched args=0. All outputs 0: req*_ready, rsp_*, EN_*, start_*, *_c, *_d.
- Reset mid-transaction abandons the transaction; no response is issued.
- FSM states: IDLE, START, READ, CHECK, RESP.
- IDLE:
  - If exactly one reqN_valid is high, grant that requester.
  - If both are high, grant requester rr_ptr.
  - reqN_ready is asserted combinationally for the granted requester only, in IDLE only.
  - On grant: latch a/b/c/d and id, set rr_ptr = ~id, clear tmo_cnt, go to START.
- START:
  - start_a/start_b are driven from the latches; EN_start = RDY_start. EN_start is never high while RDY_start is low.
  - On an edge with RDY_start=1, go to READ and clear tmo_cnt.
- READ:
  - variable_1_result_c is driven from the latch.
  - On an edge with RDY_variable_1_result=1, capture variable_1_result into rsp_result, go to CHECK, clear tmo_cnt.
- CHECK:
  - variable_1_check_d is driven from the latch; EN_variable_1_check = RDY_variable_1_check.
  - On an edge with RDY_variable_1_check=1, capture variable_1_check into rsp_check, set rsp_err=0, go to RESP.
- Timeout (START, READ, CHECK):
  - tmo_cnt increments on each edge where the phase's RDY is low.
  - If RDY is still low when tmo_cnt==TMO-1, the FSM goes to RESP with rsp_err=1.
  - On abort, result/check values not yet captured are forced to 0.
  - tmo_cnt saturates and never wraps.
- RESP:
  - rsp_valid=1, with rsp_id, rsp_result, rsp_check, rsp_err held stable until an edge with rsp_ready=1.
  - After that edge: IDLE, rsp_valid=0.
  - No new request is granted in the same cycle as rsp_ready.
- Latency with all RDYs high and rsp_ready=1: accept edge, then 1 cycle each in START, READ, CHECK. rsp_valid rises 3 cycles after accept; the next grant occurs 5 cycles after the previous accept.
- Requests arriving outside IDLE see reqN_ready=0 and must hold their arguments stable.
- rr_ptr changes only on a grant. A lone requester is granted repeatedly regardless of rr_ptr.

Test Plan:
- Single requester: req0 a=3 b=4 c=1 d=2, all RDY=1, target result=0x11, check=0x05 → EN_start for 1 cycle with start_a=3, start_b=4 → rsp_valid with id=0, result=0x11, check=0x05, err=0, 3 cycles after accept.
- Contention: both requesters valid continuously right after reset → grant order 0, 1, 0, 1; rsp_id alternates; rr_ptr ends at 0.
- RDY_start low for 10 cycles, TMO=255 → EN_start stays 0 for those 10 cycles, then pulses once; response has err=0.
- RDY_variable_1_check stuck low, TMO=4 → after 4 CHECK cycles, rsp_valid with err=1, check=0, result equal to the captured value.
- rsp_ready held low for 6 cycles → response fields are stable for all 6 cycles; req1_ready stays 0 throughout.
- RST asserted during READ → next cycle all outputs are 0 and state is IDLE; a later request completes normally.

Source files
------------

// File: rtl/design_08_sequencer.sv
// design_08_sequencer: shares one mkDesign_08 target between two requesters.
// Grants alternate round-robin on contention. Each transaction runs start(a,b),
// then a result read with c, then check(d). The captured values go back to the
// owning requester. Each method phase has a watchdog that turns a target stall
// into an error response instead of a hang.
module design_08_sequencer #(
    parameter int AW  = 5,
    parameter int RW  = 5,
    parameter int TMO = 255
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_a,
    input  logic [AW-1:0] req0_b,
    input  logic [AW-1:0] req0_c,
    input  logic [AW-1:0] req0_d,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_a,
    input  logic [AW-1:0] req1_b,
    input  logic [AW-1:0] req1_c,
    input  logic [AW-1:0] req1_d,
    output logic          req1_ready,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic [RW-1:0] rsp_result,
    output logic [RW-1:0] rsp_check,
    output logic          rsp_err,
    input  logic          rsp_ready,
    output logic [AW-1:0] start_a,
    output logic [AW-1:0] start_b,
    output logic          EN_start,
    input  logic          RDY_start,
    output logic [AW-1:0] variable_1_result_c,
    input  logic [RW-1:0] variable_1_result,
    input  logic          RDY_variable_1_result,
    output logic [AW-1:0] variable_1_check_d,
    output logic          EN_variable_1_check,
    input  logic [RW-1:0] variable_1_check,
    input  logic          RDY_variable_1_check
);

    // Counter is wide enough to hold TMO-1; the FSM leaves the phase on that value.
    localparam int TW = $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_READ  = 3'd2,
        S_CHECK = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          rr_q, rr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [AW-1:0] arg_a_q, arg_a_d;
    logic [AW-1:0] arg_b_q, arg_b_d;
    logic [AW-1:0] arg_c_q, arg_c_d;
    logic [AW-1:0] arg_d_q, arg_d_d;
    logic          id_q, id_d;
    logic [RW-1:0] result_q, result_d;
    logic [RW-1:0] check_q, check_d;
    logic          err_q, err_d;
    logic          rsp_valid_q, rsp_valid_d;

    logic          any_valid_s;
    logic          grant_id_s;
    logic          idle_s;
    logic          tmo_hit_s;

    // Arbitration: a lone requester always wins, a tie goes to the round-robin pointer.
    always_comb begin
        any_valid_s = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id_s = rr_q;
        end else if (req1_valid) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
        idle_s    = (state_q == S_IDLE) & ~RST;
        tmo_hit_s = (tmo_q == TMO_LAST);
    end

    assign req0_ready          = idle_s & req0_valid & ~grant_id_s;
    assign req1_ready          = idle_s & req1_valid & grant_id_s;
    assign EN_start            = (state_q == S_START) & RDY_start;
    assign EN_variable_1_check = (state_q == S_CHECK) & RDY_variable_1_check;
    assign start_a             = arg_a_q;
    assign start_b             = arg_b_q;
    assign variable_1_result_c = arg_c_q;
    assign variable_1_check_d  = arg_d_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_id              = id_q;
    assign rsp_result          = result_q;
    assign rsp_check           = check_q;
    assign rsp_err             = err_q;

    // Next-state logic: grant, three target phases with watchdog, then response hold.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        tmo_d    = tmo_q;
        arg_a_d  = arg_a_q;
        arg_b_d  = arg_b_q;
        arg_c_d  = arg_c_q;
        arg_d_d  = arg_d_q;
        id_d     = id_q;
        result_d = result_q;
        check_d  = check_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (any_valid_s) begin
                    arg_a_d = grant_id_s ? req1_a : req0_a;
                    arg_b_d = grant_id_s ? req1_b : req0_b;
                    arg_c_d = grant_id_s ? req1_c : req0_c;
                    arg_d_d = grant_id_s ? req1_d : req0_d;
                    id_d    = grant_id_s;
                    rr_d    = ~grant_id_s;
                    tmo_d   = {TW{1'b0}};
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (RDY_start) begin
                    tmo_d   = {TW{1'b0}};
                    state_d = S_READ;
                end else if (tmo_hit_s) begin
                    // Nothing captured yet: both return values read as zero.
                    result_d = {RW{1'b0}};
                    check_d  = {RW{1'b0}};
                    err_d    = 1'b1;
                    tmo_d    = {TW{1'b0}};
                    state_d  = S_RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_READ: begin
                if (RDY_variable_1_result) begin
                    result_d = variable_1_result;
                    tmo_d    = {TW{1'b0}};
                    state_d  = S_CHECK;
                end else if (tmo_hit_s) begin
                    result_d = {RW{1'b0}};
                    check_d  = {RW{1'b0}};
                    err_d    = 1'b1;
                    tmo_d    = {TW{1'b0}};
                    state_d  = S_RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_CHECK: begin
                if (RDY_variable_1_check) begin
                    check_d = variable_1_check;
                    err_d   = 1'b0;
                    tmo_d   = {TW{1'b0}};
                    state_d = S_RESP;
                end else if (tmo_hit_s) begin
                    // The result was already captured and is kept.
                    check_d = {RW{1'b0}};
                    err_d   = 1'b1;
                    tmo_d   = {TW{1'b0}};
                    state_d = S_RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        rsp_valid_d = (state_d == S_RESP);
    end

    // State and registered outputs; synchronous reset abandons any transaction.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            rr_q        <= 1'b0;
            tmo_q       <= {TW{1'b0}};
            arg_a_q     <= {AW{1'b0}};
            arg_b_q     <= {AW{1'b0}};
            arg_c_q     <= {AW{1'b0}};
            arg_d_q     <= {AW{1'b0}};
            id_q        <= 1'b0;
            result_q    <= {RW{1'b0}};
            check_q     <= {RW{1'b0}};
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            tmo_q       <= tmo_d;
            arg_a_q     <= arg_a_d;
            arg_b_q     <= arg_b_d;
            arg_c_q     <= arg_c_d;
            arg_d_q     <= arg_d_d;
            id_q        <= id_d;
            result_q    <= result_d;
            check_q     <= check_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_design_08_sequencer.sv
// tb_design_08_sequencer: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_design_08_sequencer;

    localparam int AW  = 5;
    localparam int RW  = 5;
    localparam int TMO = 12;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_a, req0_b, req0_c, req0_d;
    logic [AW-1:0] req1_a, req1_b, req1_c, req1_d;
    logic          req0_ready, req1_ready;
    logic          rsp_valid, rsp_id, rsp_err, rsp_ready;
    logic [RW-1:0] rsp_result, rsp_check;
    logic [AW-1:0] start_a, start_b, variable_1_result_c, variable_1_check_d;
    logic          EN_start, RDY_start, RDY_variable_1_result;
    logic          EN_variable_1_check, RDY_variable_1_check;
    logic [RW-1:0] variable_1_result, variable_1_check;

    always #5 CLK = ~CLK;

    design_08_sequencer #(.AW(AW), .RW(RW), .TMO(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
        .req0_d(req0_d), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
        .req1_d(req1_d), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_check(rsp_check), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .start_a(start_a), .start_b(start_b), .EN_start(EN_start), .RDY_start(RDY_start),
        .variable_1_result_c(variable_1_result_c), .variable_1_result(variable_1_result),
        .RDY_variable_1_result(RDY_variable_1_result),
        .variable_1_check_d(variable_1_check_d), .EN_variable_1_check(EN_variable_1_check),
        .variable_1_check(variable_1_check), .RDY_variable_1_check(RDY_variable_1_check)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;
    bit log_en   = 1'b0;
    int grant_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    // A transaction is either running one of its three method calls
    // (m_busy, m_stage = 0 start / 1 read / 2 check) or waiting to be consumed (m_resp).
    bit            m_busy = 1'b0, m_resp = 1'b0, m_next = 1'b0;
    int            m_stage = 0, m_stall = 0;
    logic [AW-1:0] m_a = '0, m_b = '0, m_c = '0, m_d = '0;
    logic          m_id = 1'b0, m_err = 1'b0;
    logic [RW-1:0] m_res = '0, m_chk = '0;

    function automatic logic pick(input logic v0, input logic v1, input logic nxt);
        if (v0 && v1) return nxt;
        return v0 ? 1'b0 : 1'b1;
    endfunction

    task automatic model_step();
        logic rdy;
        logic g;
        if (RST) begin
            m_busy = 1'b0; m_resp = 1'b0; m_next = 1'b0; m_stage = 0; m_stall = 0;
            m_a = '0; m_b = '0; m_c = '0; m_d = '0; m_id = 1'b0; m_err = 1'b0;
            m_res = '0; m_chk = '0;
        end else if (m_resp) begin
            if (rsp_ready) m_resp = 1'b0;
        end else if (m_busy) begin
            rdy = (m_stage == 0) ? RDY_start :
                  (m_stage == 1) ? RDY_variable_1_result : RDY_variable_1_check;
            if (rdy) begin
                if (m_stage == 1) m_res = variable_1_result;
                if (m_stage == 2) begin
                    m_chk = variable_1_check; m_err = 1'b0; m_busy = 1'b0; m_resp = 1'b1;
                end
                m_stage++;
                m_stall = 0;
            end else if (m_stall + 1 == TMO) begin
                m_busy = 1'b0; m_resp = 1'b1; m_err = 1'b1;
                if (m_stage < 2) m_res = '0;
                m_chk = '0;
            end else begin
                m_stall++;
            end
        end else if (req0_valid || req1_valid) begin
            g = pick(req0_valid, req1_valid, m_next);
            m_id = g; m_next = ~g;
            m_a = g ? req1_a : req0_a; m_b = g ? req1_b : req0_b;
            m_c = g ? req1_c : req0_c; m_d = g ? req1_d : req0_d;
            m_busy = 1'b1; m_stage = 0; m_stall = 0;
        end
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge CLK);
        if (mon_en && !RST) begin
            logic idle, g;
            idle = !m_busy && !m_resp;
            g = pick(req0_valid, req1_valid, m_next);
            chk("handshake",
                {27'd0, req0_ready, req1_ready, EN_start, EN_variable_1_check, rsp_valid},
                {27'd0, idle && req0_valid && !g, idle && req1_valid && g,
                 m_busy && m_stage == 0 && RDY_start,
                 m_busy && m_stage == 2 && RDY_variable_1_check, m_resp});
            if (m_busy && m_stage == 0) chk("start_args", {22'd0, start_a, start_b}, {22'd0, m_a, m_b});
            if (m_busy && m_stage == 1) chk("result_c", {27'd0, variable_1_result_c}, {27'd0, m_c});
            if (m_busy && m_stage == 2) chk("check_d", {27'd0, variable_1_check_d}, {27'd0, m_d});
            if (m_resp) chk("response", {20'd0, rsp_id, rsp_result, rsp_check, rsp_err},
                            {20'd0, m_id, m_res, m_chk, m_err});
            if (log_en && req0_valid && req0_ready) grant_log.push_back(0);
            if (log_en && req1_valid && req1_ready) grant_log.push_back(1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_c = '0; req0_d = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_c = '0; req1_d = '0;
        rsp_ready = 1'b1; RDY_start = 1'b1; RDY_variable_1_result = 1'b1;
        RDY_variable_1_check = 1'b1; variable_1_result = '0; variable_1_check = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rsp"}, {17'd0, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result,
                            rsp_check, rsp_err}, 32'd0);
        chk({tag, "_target"}, {10'd0, start_a, start_b, EN_start, variable_1_result_c,
                               variable_1_check_d, EN_variable_1_check}, 32'd0);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        if (!rsp_valid) chk("rsp_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic start_stall(input int lows, input logic exp_err);
        int n;
        idle_inputs();
        req0_valid = 1'b1; req0_a = 5'd9; req0_b = 5'd10; req0_c = 5'd11; req0_d = 5'd12;
        RDY_start = 1'b0; variable_1_result = 5'h07; variable_1_check = 5'h19;
        tick();
        req0_valid = 1'b0;
        repeat (lows) tick();
        RDY_start = 1'b1;
        wait_rsp(n);
        if (exp_err) chk("start_abort", {21'd0, rsp_err, rsp_result, rsp_check}, {21'd0, 1'b1, 5'h00, 5'h00});
        else         chk("start_no_abort", {21'd0, rsp_err, rsp_result, rsp_check}, {21'd0, 1'b0, 5'h07, 5'h19});
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int exp_grants[5];
        logic acc0, acc1;
        bit fast;
        exp_grants = '{0, 1, 0, 1, 0};

        idle_inputs();
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        mon_en = 1'b1;
        settle();
        check_reset_outputs("reset");

        // Single requester, all ready.
        req0_valid = 1'b1; req0_a = 5'd3; req0_b = 5'd4; req0_c = 5'd1; req0_d = 5'd2;
        variable_1_result = 5'h11; variable_1_check = 5'h05;
        settle();
        chk("t1_ready", {30'd0, req0_ready, req1_ready}, 32'd2);
        tick();
        req0_valid = 1'b0;
        settle();
        chk("t1_en_start", {21'd0, EN_start, start_a, start_b}, {21'd0, 1'b1, 5'd3, 5'd4});
        tick(); settle();
        chk("t1_en_start_once", {31'd0, EN_start}, 32'd0);
        tick(); tick(); settle();
        chk("t1_response", {19'd0, rsp_valid, rsp_id, rsp_result, rsp_check, rsp_err},
            {19'd0, 1'b1, 1'b0, 5'h11, 5'h05, 1'b0});
        tick(); settle();
        chk("t1_rsp_done", {31'd0, rsp_valid}, 32'd0);

        // Contention from reset: grants alternate starting with requester 0.
        RST = 1'b1; tick(); RST = 1'b0;
        idle_inputs();
        grant_log.delete();
        log_en = 1'b1;
        req0_valid = 1'b1; req0_a = 5'd1; req0_b = 5'd2; req0_c = 5'd3; req0_d = 5'd4;
        req1_valid = 1'b1; req1_a = 5'd21; req1_b = 5'd22; req1_c = 5'd23; req1_d = 5'd24;
        variable_1_result = 5'h0E; variable_1_check = 5'h1B;
        n = 0;
        while (grant_log.size() < 5 && n < 40) begin
            tick();
            n++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        log_en = 1'b0;
        chk("t2_grant_count", grant_log.size(), 32'd5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            chk($sformatf("t2_grant%0d", i), grant_log[i], exp_grants[i]);
        repeat (6) tick();

        // Start stalled for 10 cycles: no abort, single enable pulse.
        idle_inputs();
        req1_valid = 1'b1; req1_a = 5'd7; req1_b = 5'd9; req1_c = 5'd2; req1_d = 5'd6;
        RDY_start = 1'b0; variable_1_result = 5'h0A; variable_1_check = 5'h14;
        settle();
        chk("t3_ready", {30'd0, req0_ready, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("t3_en_start_low", {31'd0, EN_start}, 32'd0);
            tick();
        end
        RDY_start = 1'b1;
        settle();
        chk("t3_en_start_pulse", {21'd0, EN_start, start_a, start_b}, {21'd0, 1'b1, 5'd7, 5'd9});
        tick(); settle();
        chk("t3_en_start_done", {31'd0, EN_start}, 32'd0);
        wait_rsp(n);
        chk("t3_response", {20'd0, rsp_id, rsp_result, rsp_check, rsp_err},
            {20'd0, 1'b1, 5'h0A, 5'h14, 1'b0});
        tick();

        // Watchdog boundary in START: TMO-1 low cycles survive, TMO abort.
        start_stall(TMO - 1, 1'b0);
        start_stall(TMO, 1'b1);

        // Check stuck low: abort after TMO check cycles, result kept.
        idle_inputs();
        req0_valid = 1'b1; req0_a = 5'd1; req0_b = 5'd2; req0_c = 5'd3; req0_d = 5'd4;
        RDY_variable_1_check = 1'b0; variable_1_result = 5'h1A; variable_1_check = 5'h1F;
        tick();
        req0_valid = 1'b0;
        wait_rsp(n);
        chk("t4_latency", n, 32'd14);
        chk("t4_response", {20'd0, rsp_id, rsp_result, rsp_check, rsp_err},
            {20'd0, 1'b0, 5'h1A, 5'h00, 1'b1});
        RDY_variable_1_check = 1'b1;
        tick();

        // Response held for 6 cycles; a waiting requester is not granted.
        idle_inputs();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 5'd5; req0_b = 5'd6; req0_c = 5'd7; req0_d = 5'd8;
        variable_1_result = 5'h0C; variable_1_check = 5'h15;
        tick();
        req0_valid = 1'b0;
        wait_rsp(n);
        req1_valid = 1'b1; req1_a = 5'd30; req1_b = 5'd29; req1_c = 5'd28; req1_d = 5'd27;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("t5_hold", {18'd0, rsp_valid, rsp_id, rsp_result, rsp_check, rsp_err, req1_ready},
                {18'd0, 1'b1, 1'b0, 5'h0C, 5'h15, 1'b0, 1'b0});
            tick();
        end
        rsp_ready = 1'b1;
        settle();
        chk("t5_no_grant_on_consume", {31'd0, req1_ready}, 32'd0);
        tick(); settle();
        chk("t5_grant_after", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        wait_rsp(n);
        tick();

        // Reset while in READ, then a clean transaction.
        idle_inputs();
        req0_valid = 1'b1; req0_a = 5'd17; req0_b = 5'd18; req0_c = 5'd19; req0_d = 5'd20;
        RDY_variable_1_result = 1'b0;
        tick();
        req0_valid = 1'b0;
        tick(); settle();
        chk("t6_in_read", {27'd0, variable_1_result_c}, 32'd19);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        settle();
        check_reset_outputs("t6_reset");
        repeat (3) tick();
        chk("t6_no_response", {31'd0, rsp_valid}, 32'd0);
        idle_inputs();
        req1_valid = 1'b1; req1_a = 5'd2; req1_b = 5'd3; req1_c = 5'd4; req1_d = 5'd5;
        variable_1_result = 5'h13; variable_1_check = 5'h08;
        tick();
        req1_valid = 1'b0;
        wait_rsp(n);
        chk("t6_after_reset", {20'd0, rsp_id, rsp_result, rsp_check, rsp_err},
            {20'd0, 1'b1, 5'h13, 5'h08, 1'b0});
        tick();

        // Randomized traffic, including slow-target windows and rare resets.
        acc0 = 1'b0; acc1 = 1'b0; fast = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 150 == 0) fast = ($urandom_range(0, 2) != 0);
            RST = ($urandom_range(0, 499) == 0);
            rsp_ready = ($urandom_range(0, 9) < 7);
            RDY_start             = fast ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 8);
            RDY_variable_1_result = fast ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 8);
            RDY_variable_1_check  = fast ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 8);
            variable_1_result = RW'($urandom);
            variable_1_check  = RW'($urandom);
            if (!req0_valid || acc0) begin
                req0_valid = $urandom_range(0, 1);
                req0_a = AW'($urandom); req0_b = AW'($urandom);
                req0_c = AW'($urandom); req0_d = AW'($urandom);
            end
            if (!req1_valid || acc1) begin
                req1_valid = $urandom_range(0, 1);
                req1_a = AW'($urandom); req1_b = AW'($urandom);
                req1_c = AW'($urandom); req1_d = AW'($urandom);
            end
            settle();
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            tick();
        end
        RST = 1'b0;
        idle_inputs();
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
